// File: rtl/gesture_vote_filter_if.sv
// rtl/gesture_vote_filter_if.sv - classifier sample and confirmation signal bundle
interface gesture_vote_filter_if #(
  parameter int CLASS_W      = 2,
  parameter int ACC_SUM_BITS = 18
);
  logic [CLASS_W-1:0]      class_gesture;
  logic                    class_valid;
  logic                    class_pass;
  logic [ACC_SUM_BITS-1:0] abs_delta_x;
  logic [ACC_SUM_BITS-1:0] abs_delta_y;
  logic [CLASS_W-1:0]      gesture;
  logic                    gesture_valid;
  logic [3:0]              gesture_confidence;
  logic                    suppressed;
  logic [1:0]              debug_state;
  logic [3:0]              debug_match_count;

  modport master (
    output class_gesture, class_valid, class_pass, abs_delta_x, abs_delta_y,
    input  gesture, gesture_valid, gesture_confidence, suppressed,
           debug_state, debug_match_count
  );

  modport slave (
    input  class_gesture, class_valid, class_pass, abs_delta_x, abs_delta_y,
    output gesture, gesture_valid, gesture_confidence, suppressed,
           debug_state, debug_match_count
  );
endinterface

// File: rtl/gesture_vote_filter.sv
// rtl/gesture_vote_filter.sv - persistence vote, timeout and cooldown filter for gesture classes
module gesture_vote_filter #(
  parameter int NUM_CLASSES       = 4,
  parameter int CLASS_W           = 2,
  parameter int ACC_SUM_BITS      = 18,
  parameter int PERSISTENCE_COUNT = 2,
  parameter int COOLDOWN_CYCLES   = 64,
  parameter int TIMEOUT_CYCLES    = 1024,
  parameter int CONF_SHIFT        = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  gesture_vote_filter_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, TRACKING = 2'd1, COOLDOWN = 2'd2} state_t;

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
  localparam int CD_W  = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
  localparam logic [TMR_W-1:0]   TMR_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CD_W-1:0]    CD_LAST   = CD_W'((COOLDOWN_CYCLES > 0) ? COOLDOWN_CYCLES - 1 : 0);
  localparam logic [3:0]         PERSIST   = 4'(PERSISTENCE_COUNT);
  localparam logic [CLASS_W:0]   NUM_CLS_V = (CLASS_W + 1)'(NUM_CLASSES);

  state_t               state, state_n;
  logic [CLASS_W-1:0]   candidate, candidate_n;
  logic [3:0]           match_count, match_n;
  logic [TMR_W-1:0]     timer, timer_n;
  logic [CD_W-1:0]      cd_cnt, cd_n;
  logic [CLASS_W-1:0]   gesture_r, gesture_n;
  logic [3:0]           conf_r, conf_n;
  logic                 gv_r, gv_n;
  logic                 sup_r, sup_n;
  logic                 accepted;
  logic                 do_confirm;

  logic [ACC_SUM_BITS-1:0] dom, dom_shift;
  logic [3:0]              conf_calc;

  // A tie between the axes deliberately selects y.
  assign dom       = (bus.abs_delta_x > bus.abs_delta_y) ? bus.abs_delta_x : bus.abs_delta_y;
  assign dom_shift = dom >> CONF_SHIFT;
  assign conf_calc = (dom_shift > ACC_SUM_BITS'(15)) ? 4'd15 : dom_shift[3:0];
  assign accepted  = bus.class_valid && bus.class_pass &&
                     ({1'b0, bus.class_gesture} < NUM_CLS_V);

  always_comb begin
    state_n     = state;
    candidate_n = candidate;
    match_n     = match_count;
    timer_n     = timer;
    cd_n        = cd_cnt;
    gesture_n   = gesture_r;
    conf_n      = conf_r;
    gv_n        = 1'b0;
    sup_n       = 1'b0;
    do_confirm  = 1'b0;
    case (state)
      IDLE: begin
        if (accepted) begin
          candidate_n = bus.class_gesture;
          match_n     = 4'd1;
          timer_n     = '0;
          state_n     = TRACKING;
          do_confirm  = (PERSIST == 4'd1);
        end
      end
      TRACKING: begin
        if (bus.class_valid) begin
          timer_n = '0;
          if (!accepted) begin
            match_n = 4'd0;
            state_n = IDLE;
          end else if (bus.class_gesture == candidate) begin
            match_n    = match_count + 4'd1;
            do_confirm = (match_n == PERSIST);
          end else begin
            candidate_n = bus.class_gesture;
            match_n     = 4'd1;
            do_confirm  = (PERSIST == 4'd1);
          end
        end else if (timer == TMR_LAST) begin
          timer_n = '0;
          match_n = 4'd0;
          state_n = IDLE;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      COOLDOWN: begin
        sup_n = bus.class_valid;
        if (cd_cnt == CD_LAST) begin
          cd_n    = '0;
          state_n = IDLE;
        end else begin
          cd_n = cd_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (do_confirm) begin
      gv_n      = 1'b1;
      gesture_n = candidate_n;
      conf_n    = conf_calc;
      match_n   = 4'd0;
      timer_n   = '0;
      cd_n      = '0;
      state_n   = (COOLDOWN_CYCLES == 0) ? IDLE : COOLDOWN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      candidate   <= '0;
      match_count <= 4'd0;
      timer       <= '0;
      cd_cnt      <= '0;
      gesture_r   <= '0;
      conf_r      <= 4'd0;
      gv_r        <= 1'b0;
      sup_r       <= 1'b0;
    end else begin
      state       <= state_n;
      candidate   <= candidate_n;
      match_count <= match_n;
      timer       <= timer_n;
      cd_cnt      <= cd_n;
      gesture_r   <= gesture_n;
      conf_r      <= conf_n;
      gv_r        <= gv_n;
      sup_r       <= sup_n;
    end
  end

  assign bus.gesture            = gesture_r;
  assign bus.gesture_valid      = gv_r;
  assign bus.gesture_confidence = conf_r;
  assign bus.suppressed         = sup_r;
  assign bus.debug_state        = state;
  assign bus.debug_match_count  = match_count;
endmodule

// File: doc/gesture_vote_filter.md
GESTURE_VOTE_FILTER -- requirements
Module: gesture_vote_filter

Interface
REQ-001 SHALL have parameter NUM_CLASSES, default 4: number of legal gesture classes (2..16).
REQ-002 SHALL have parameter CLASS_W, default 2: width of class ports; 2**CLASS_W >= NUM_CLASSES.
REQ-003 SHALL have parameter ACC_SUM_BITS, default 18: width of the magnitude inputs.
REQ-004 SHALL have parameter PERSISTENCE_COUNT, default 2: consecutive matching passes required (1..15).
REQ-005 SHALL have parameter COOLDOWN_CYCLES, default 64: post-confirmation lockout length in clk cycles (0 = none).
REQ-006 SHALL have parameter TIMEOUT_CYCLES, default 1024: TRACKING abandon interval in cycles (>= 2).
REQ-007 SHALL have parameter CONF_SHIFT, default 4: right shift applied to the dominant magnitude for confidence.
REQ-008 SHALL have port clk  input  1  sole clock, rising edge.
REQ-009 SHALL have port rst  input  1  synchronous reset, active-high.
REQ-010 SHALL have port class_gesture  input  CLASS_W  candidate class.
REQ-011 SHALL have port class_valid  input  1  single-cycle strobe qualifying class_gesture, class_pass and the magnitudes.
REQ-012 SHALL have port class_pass  input  1  upstream threshold met.
REQ-013 SHALL have ports abs_delta_x and abs_delta_y  input  ACC_SUM_BITS each  unsigned motion magnitudes.
REQ-014 SHALL have port gesture  output  CLASS_W  last confirmed class.
REQ-015 SHALL have port gesture_valid  output  1  one-cycle confirmation pulse.
REQ-016 SHALL have port gesture_confidence  output  4  confidence of the last confirmation.
REQ-017 SHALL have port suppressed  output  1  one-cycle pulse when a class_valid is discarded during COOLDOWN.
REQ-018 SHALL have port debug_state  output  2  encoding: IDLE=0, TRACKING=1, COOLDOWN=2.
REQ-019 SHALL have port debug_match_count  output  4  current run length.

Function
REQ-020 SHALL treat a sample as "accepted" when class_valid=1, class_pass=1 and class_gesture < NUM_CLASSES; any other class_valid=1 sample is a "reject".
REQ-021 IDLE, on accepted: candidate <= class, match_count <= 1, go to TRACKING; if PERSISTENCE_COUNT=1, confirm instead (REQ-024).
REQ-022 TRACKING, accepted with same class: match_count+1; confirm when the new count equals PERSISTENCE_COUNT. Accepted with a different class: candidate <= new class, match_count <= 1. Reject: match_count <= 0, go to IDLE.
REQ-023 TRACKING timeout: timer clears on entry and on every class_valid. When the timer reaches TIMEOUT_CYCLES-1 with class_valid=0, go to IDLE with match_count <= 0. A class_valid arriving on the timeout cycle is processed normally, and the timeout is not taken.
REQ-024 Confirm, registered one cycle after the deciding class_valid:
  - gesture_valid=1 for exactly one cycle;
  - gesture <= candidate;
  - confidence updated (REQ-025);
  - match_count <= 0;
  - next state is COOLDOWN, or IDLE if COOLDOWN_CYCLES=0.
REQ-025 Confidence: dom = abs_delta_x if abs_delta_x > abs_delta_y, else abs_delta_y (a tie selects y). conf = dom >> CONF_SHIFT, saturated to 15. Both inputs are sampled on the deciding class_valid.
REQ-026 COOLDOWN:
  - counter runs 0..COOLDOWN_CYCLES-1, then returns to IDLE;
  - every class_valid in COOLDOWN is discarded and pulses suppressed one cycle later;
  - a class_valid on the final COOLDOWN cycle is also discarded.
REQ-027 gesture and gesture_confidence SHALL hold their values between confirmations.
REQ-028 In every state, class_valid=0 SHALL leave candidate and match_count unchanged (except on timeout).
REQ-029 All outputs SHALL be registered, with no combinational path from inputs to outputs.
REQ-030 Counters SHALL be sized by $clog2 of their limits and SHALL never wrap.

Reset
REQ-031 rst=1 SHALL, at the next clock edge, force:
  - state IDLE;
  - gesture=0, gesture_valid=0, gesture_confidence=0, suppressed=0;
  - match_count=0, candidate=0, timer=0, cooldown counter=0.
REQ-032 Reset asserted mid-TRACKING or mid-COOLDOWN SHALL abort it, with no gesture_valid pulse.
REQ-033 A class_valid coincident with rst=1 SHALL be ignored.

Verification
REQ-034 Basic confirm (defaults): two accepted class 2, 10 cycles apart, abs_x=100, abs_y=40 -> one gesture_valid pulse one cycle after the second, gesture=2, confidence=6, debug_state=2.
REQ-035 Class switch: accepted 1, accepted 3, accepted 3 -> a single pulse after the third, gesture=3; no pulse after the second.
REQ-036 Cooldown: after a confirm, an accepted class 0 at cooldown cycle 10 -> suppressed pulse, no state change; IDLE after 64 cycles; two further accepted 0s -> confirm.
REQ-037 Timeout and tie: accepted 1, then 1024 idle cycles -> IDLE, match_count=0. Next: a pair of accepted 1 with abs_x=abs_y=5000 -> confidence=15 (saturation, y selected).
REQ-038 Rejects: accepted 2, then class_pass=0 -> IDLE; class_gesture=3 with NUM_CLASSES=3 -> treated as a reject, never confirmed.
REQ-039 Reset: rst pulsed between the two matching samples -> no pulse; the post-reset sample starts a new run with match_count=1.
